// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit for the 16-bit CPU: fetch, decode, M read, execute, write-back.
// Define CPU_HALT_DETECT_EN to stop in a HALT state on an unconditional jump to its own PC.
module cpu_ctrl #(
  parameter int ADDR_W   = 15,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [15:0]       dmem_rdata,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [5:0]        alu_sel,
  input  logic [15:0]       alu_out,
  input  logic [2:0]        alu_flag,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_MRD    = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
`ifdef CPU_HALT_DETECT_EN
  localparam logic [2:0] S_HALT   = 3'd5;
`endif

  logic [2:0]        state_q, state_d;
  logic              run_q;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       a_q, a_d;
  logic [15:0]       d_q, d_d;
  logic [15:0]       m_q, m_d;
  logic [15:0]       r_q, r_d;
  logic [2:0]        f_q, f_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              is_c, use_m, dest_a, dest_d, dest_m;
  logic              taken, fetch_fire, wb_done;
  logic [ADDR_W-1:0] pc_inc;

  assign is_c   = ir_q[15];
  assign use_m  = ir_q[12];
  assign dest_a = ir_q[5];
  assign dest_d = ir_q[4];
  assign dest_m = ir_q[3];
  assign pc_inc = pc_q + ADDR_W'(1);

  // Flag values other than 0..2 never satisfy a jump condition.
  assign taken = (ir_q[2] && f_q == 3'd0) ||
                 (ir_q[1] && f_q == 3'd1) ||
                 (ir_q[0] && f_q == 3'd2);

  // run_q holds off the first fetch until the cycle after reset is released.
  assign fetch_fire = imem_req & imem_ack;
  assign wb_done    = (state_q == S_WB) && (!dest_m || dmem_ack);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    d_d     = d_q;
    m_d     = m_q;
    r_d     = r_q;
    f_d     = f_q;
    pc_d    = pc_q;
    case (state_q)
      S_FETCH: begin
        if (fetch_fire) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!is_c) begin
          a_d     = ir_q;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else if (use_m) begin
          state_d = S_MRD;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_MRD: begin
        if (dmem_ack) begin
          m_d     = dmem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        r_d     = alu_out;
        f_d     = alu_flag;
        state_d = S_WB;
      end
      S_WB: begin
        if (wb_done) begin
          // a_q here is still the value from instruction start.
          if (dest_a) a_d = r_q;
          if (dest_d) d_d = r_q;
          pc_d    = taken ? a_q[ADDR_W-1:0] : pc_inc;
          state_d = S_FETCH;
`ifdef CPU_HALT_DETECT_EN
          if (ir_q[2:0] == 3'b111 && a_q[ADDR_W-1:0] == pc_q) state_d = S_HALT;
`endif
        end
      end
`ifdef CPU_HALT_DETECT_EN
      S_HALT:  state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      ir_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      f_q     <= '0;
      pc_q    <= ADDR_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      ir_q    <= ir_d;
      a_q     <= a_d;
      d_q     <= d_d;
      m_q     <= m_d;
      r_q     <= r_d;
      f_q     <= f_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_req   = (state_q == S_FETCH) && run_q;
  assign imem_addr  = pc_q;
  assign pc_o       = pc_q;
  assign dmem_req   = (state_q == S_MRD) || (state_q == S_WB && dest_m);
  assign dmem_we    = (state_q == S_WB) && dest_m;
  assign dmem_addr  = a_q[ADDR_W-1:0];
  assign dmem_wdata = r_q;
  assign alu_a      = d_q;
  assign alu_b      = (is_c && use_m) ? m_q : a_q;
  // Select bits are packed {no,f,nb,zb,na,za}, i.e. IR[11:6] reversed.
  assign alu_sel    = (state_q == S_EXEC) ?
                      {ir_q[6], ir_q[7], ir_q[8], ir_q[9], ir_q[10], ir_q[11]} : 6'd0;
`ifdef CPU_HALT_DETECT_EN
  assign halted     = (state_q == S_HALT);
`else
  assign halted     = 1'b0;
`endif

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control unit for the 16-bit CPU, sitting directly upstream of the ALU. Each instruction goes through fetch, decode, optional memory read, execute and write-back. The block owns the A, D and PC registers. It drives the ALU operands and 6-bit select, and consumes the ALU result and flag to write back registers and memory and to resolve jumps.

## Interface
Parameters:
- ADDR_W, 15, instruction/data address width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address (PC)
- imem_ack  in  1  fetch complete; imem_rdata valid
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_W  data address (A[ADDR_W-1:0])
- dmem_wdata  out  16  write data
- dmem_ack  in  1  data transfer complete
- dmem_rdata  in  16  read data
- alu_a  out  16  ALU operand a (D register)
- alu_b  out  16  ALU operand b (A or M)
- alu_sel  out  6  {no,f,nb,zb,na,za}
- alu_out  in  16  ALU result
- alu_flag  in  3  ALU flag: 0 negative, 1 zero, 2 positive
- pc_o  out  ADDR_W  current PC
- halted  out  1  halt indication (see Configuration)

## Operation
- Instruction word, bit 15:
  - IR[15]=0 is an A-instruction: A <= IR.
  - IR[15]=1 is a C-instruction with fields a=IR[12], comp=IR[11:6], dest=IR[5:3] {A,D,M}, jump=IR[2:0] {lt,eq,gt}.
- alu_sel mapping: za=IR[11], na=IR[10], zb=IR[9], nb=IR[8], f=IR[7], no=IR[6]. The f and no bits pass through verbatim.
- States:
  - FETCH: imem_req=1, imem_addr=PC. On imem_ack, IR <= imem_rdata and go to DECODE.
  - DECODE:
    - A-instr: A <= IR, PC <= PC+1, go to FETCH.
    - C-instr with a=1: go to MRD.
    - C-instr with a=0: go to EXEC.
  - MRD: dmem_req=1, dmem_we=0, dmem_addr=A. On dmem_ack, M <= dmem_rdata and go to EXEC.
  - EXEC: alu_a=D, alu_b = a ? M : A, alu_sel from IR. Latch R <= alu_out and F <= alu_flag, then go to WB.
  - WB:
    - If dest.M: dmem_req=1, dmem_we=1, dmem_addr=A, dmem_wdata=R. Hold in WB until dmem_ack.
    - On completion, in a single cycle:
      - if dest.A, A <= R;
      - if dest.D, D <= R;
      - if taken, PC <= A[ADDR_W-1:0], else PC <= PC+1;
      - go to FETCH.
- Jump rule: taken = (jump.lt & F==0) | (jump.eq & F==1) | (jump.gt & F==2).
  - F==3 is treated as no condition met.
- Same-instruction hazards:
  - The jump target and M address use A as it was at instruction start. A dest.A update does not affect that instruction's jump or write address.
- PC arithmetic is modulo 2^ADDR_W; PC = all-ones wraps to 0.
- Outputs outside their active state:
  - imem_req and dmem_req are 0.
  - alu_a and alu_b keep tracking D and the selected operand.
  - alu_sel is 0.

## Timing
- Reset (synchronous):
  - A=0, D=0, IR=0, R=0, PC=RESET_PC, state=FETCH.
  - All outputs: imem_req=0, dmem_req=0, dmem_we=0, dmem_wdata=0, halted=0, alu_sel=0.
  - The first fetch request appears in the cycle after rst deasserts.
- Handshake:
  - A req stays high and its address/data stay stable until the cycle in which ack=1 is sampled.
  - req drops in the following cycle. Acks outside a request are ignored.
- Minimum latency with ack returned the same cycle:
  - A-instr: 2 cycles.
  - C-instr without M access: 4 cycles.
  - +1 cycle for an M read. An M write adds 0 cycles beyond waiting in WB.
- Reset mid-transaction: any request is abandoned and req is 0 in the cycle after rst is sampled. Partial results are discarded.
- ALU is combinational and is sampled at the end of the single EXEC cycle.

## Configuration
- CPU_HALT_DETECT_EN:
  - Defined: a C-instruction with jump=111 whose target A equals its own PC enters HALT instead of FETCH.
    - In HALT: halted=1, no requests, registers frozen; only rst exits.
  - Undefined: no HALT state; halted is tied to 0 and the self-jump loops forever through FETCH.

## Test plan
- Reset then A-instr 0x0005 at PC 0 -> A=5, PC=1 two cycles after ack, no dmem_req.
- A=5 preloaded, D=3, C-instr D=D+A (comp 000010, dest D) -> ALU sees a=3, b=5; D=8 after WB; PC=2.
- A=0x0010, memory[0x10]=0x1234, M=M (comp 110000, dest M) -> one dmem read at 0x10, then one write of alu_out at 0x10 held until a delayed ack (3 cycles).
- A=0x0020, D=0xFFFF, D;JLT with ALU flag=0 -> PC=0x20. With JGT and the same flag -> PC=old+1.
- dest=A with jump=111, A=0x0040 at start, ALU result 0x0099 -> PC=0x40, A=0x0099.
- rst asserted while dmem_req=1 and ack pending -> dmem_req=0 next cycle, PC=RESET_PC, D unchanged from 0. With CPU_HALT_DETECT_EN, "@N; 0;JMP" at PC N -> halted=1, requests stay 0.
